// File: rtl/pe_act_queue_pkg.sv
// ----------------------------------------------------------------------------
// pe_act_queue_pkg
//   Shared definitions for the PE activation queue.
//   Provides the default geometry of the queue and of the activation entries.
//   An entry on the push bus is {idx, data}, with idx in the upper bits.
// ----------------------------------------------------------------------------
package pe_act_queue_pkg;

  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IDX_WIDTH  = 10;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage : pe_act_queue_pkg

// File: rtl/pe_act_queue_sync_fifo_ptr.sv
// ----------------------------------------------------------------------------
// pe_act_queue_sync_fifo_ptr
//   Read/write pointer and occupancy bookkeeping for a synchronous FIFO.
//   Reusable by any PE-local queue that keeps its own storage array.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   i_clr        synchronous clear of pointers and count; wins over push/pop
//   i_push       push request
//   i_pop        pop request (caller guarantees the FIFO is not empty)
//   o_wr_ptr     slot the next accepted push writes
//   o_rd_ptr     slot currently at the head
//   o_count      occupancy, 0..DEPTH
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
//   o_push_acc   push takes effect this cycle (write-enable for the array)
//   o_push_drop  push discarded because the FIFO is full and nothing pops
// ----------------------------------------------------------------------------
module pe_act_queue_sync_fifo_ptr
  import pe_act_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_push_acc,
  output logic          o_push_drop
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

  assign w_pop       = i_pop & ~i_clr;
  // A pop in the same cycle frees the slot, so a push is still accepted at full.
  assign o_push_acc  = i_push & (~o_full | w_pop) & ~i_clr;
  assign o_push_drop = i_push & o_full & ~w_pop & ~i_clr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are DEPTH-sized (power of two), so they wrap to 0 on their own.
      if (o_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({o_push_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule : pe_act_queue_sync_fifo_ptr

// File: rtl/pe_act_queue.sv
// ----------------------------------------------------------------------------
// pe_act_queue
//   First-word-fall-through activation queue between the network interface
//   push path and the PE MAC datapath. pop_act goes back to the network
//   interface so it can release the credit for the freed slot.
//
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   push_act/act  push strobe and entry {idx, data} from the network interface
//   pop_act       head consumed this cycle
//   head_valid    head entry present; head_idx/head_data are 0 when not valid
//   mac_ready     MAC accepts the head this cycle
//   flush         layer boundary: clears contents and consumed_cnt next cycle
//   count/full/empty  occupancy status
//   consumed_cnt  saturating count of pops since reset or flush
//   overflow_err  sticky: a push was dropped at full (cleared only by reset)
// ----------------------------------------------------------------------------
module pe_act_queue
  import pe_act_queue_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int BUS_W     = IDX_WIDTH + DATA_WIDTH,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_act,
  input  logic [BUS_W-1:0]      act,
  output logic                  pop_act,
  output logic                  head_valid,
  output logic [IDX_WIDTH-1:0]  head_idx,
  output logic [DATA_WIDTH-1:0] head_data,
  input  logic                  mac_ready,
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  consumed_cnt,
  output logic                  overflow_err
);

  logic [BUS_W-1:0]     r_mem [DEPTH];
  logic [CNT_WIDTH-1:0] r_consumed;
  logic                 r_overflow;

  logic [PW-1:0]        w_wr_ptr;
  logic [PW-1:0]        w_rd_ptr;
  logic                 w_push_acc;
  logic                 w_push_drop;
  logic [BUS_W-1:0]     w_head;

  pe_act_queue_sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (flush),
    .i_push      (push_act),
    .i_pop       (pop_act),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (count),
    .o_full      (full),
    .o_empty     (empty),
    .o_push_acc  (w_push_acc),
    .o_push_drop (w_push_drop)
  );

  assign head_valid = ~empty;
  assign pop_act    = head_valid & mac_ready & ~flush;

  // NOTE: the storage array has no reset; entries are only observable once
  // written, so resetting it would add a reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[w_wr_ptr] <= act;
  end

  // Masking with head_valid keeps never-written (unknown) slots off the bus
  // and gives the all-zero head the queue shows out of reset.
  assign w_head    = head_valid ? r_mem[w_rd_ptr] : '0;
  assign head_idx  = w_head[BUS_W-1 -: IDX_WIDTH];
  assign head_data = w_head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_consumed <= '0;
    end else if (flush) begin
      r_consumed <= '0;
    end else if (pop_act && (r_consumed != '1)) begin
      r_consumed <= r_consumed + 1'b1;
    end
  end

  // Flush deliberately leaves the error flag alone: it records a credit
  // protocol violation, which must survive layer boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_push_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign consumed_cnt = r_consumed;
  assign overflow_err = r_overflow;

endmodule : pe_act_queue

// File: tb/tb_pe_act_queue.sv
// ----------------------------------------------------------------------------
// tb_pe_act_queue
//   Self-checking bench: a queue-based reference model tracks the expected
//   contents; a compare process checks every output at each falling edge,
//   and directed scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_pe_act_queue;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int IW    = 10;
  localparam int CNTW  = 16;
  localparam int BW    = IW + DW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          push_act;
  logic [BW-1:0] act;
  logic          pop_act;
  logic          head_valid;
  logic [IW-1:0] head_idx;
  logic [DW-1:0] head_data;
  logic          mac_ready;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [CNTW-1:0] consumed_cnt;
  logic          overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  pe_act_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .CNT_WIDTH(CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_act     (push_act),
    .act          (act),
    .pop_act      (pop_act),
    .head_valid   (head_valid),
    .head_idx     (head_idx),
    .head_data    (head_data),
    .mac_ready    (mac_ready),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .consumed_cnt (consumed_cnt),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [BW-1:0] m_q[$];
  int            m_consumed;
  bit            m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_consumed = 0;
      m_ovf      = 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_consumed = 0;
    end else begin
      bit pop_now;
      bit room;
      pop_now = (m_q.size() != 0) && mac_ready;
      room    = (m_q.size() < DEPTH) || pop_now;
      if (pop_now) begin
        void'(m_q.pop_front());
        if (m_consumed < (1 << CNTW) - 1) m_consumed++;
      end
      if (push_act) begin
        if (room) m_q.push_back(act);
        else      m_ovf = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      bit            e_hv;
      logic [BW-1:0] e_head;
      e_hv   = (m_q.size() != 0);
      e_head = e_hv ? m_q[0] : '0;
      check("cmp_head_valid", 64'(head_valid), 64'(e_hv));
      check("cmp_head_idx",   64'(head_idx),   64'(e_head[BW-1 -: IW]));
      check("cmp_head_data",  64'(head_data),  64'(e_head[DW-1:0]));
      check("cmp_pop_act",    64'(pop_act),    64'(e_hv && mac_ready && !flush));
      check("cmp_count",      64'(count),      64'(m_q.size()));
      check("cmp_full",       64'(full),       64'(m_q.size() == DEPTH));
      check("cmp_empty",      64'(empty),      64'(m_q.size() == 0));
      check("cmp_consumed",   64'(consumed_cnt), 64'(m_consumed));
      check("cmp_overflow",   64'(overflow_err), 64'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit p, input logic [BW-1:0] a, input bit r, input bit f);
    push_act  = p;
    act       = a;
    mac_ready = r;
    flush     = f;
  endtask

  task automatic cyc(input bit p, input logic [BW-1:0] a, input bit r, input bit f);
    set_in(p, a, r, f);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] mk(input int idx, input int data);
    return {IW'(idx), DW'(data)};
  endfunction

  // ---------------- directed + random scenarios ----------------
  initial begin
    rst = 1'b0;
    set_in(0, '0, 0, 0);
    #12;
    check("rst_pop_act",    64'(pop_act), 0);
    check("rst_head_valid", 64'(head_valid), 0);
    check("rst_head_idx",   64'(head_idx), 0);
    check("rst_head_data",  64'(head_data), 0);
    check("rst_count",      64'(count), 0);
    check("rst_full",       64'(full), 0);
    check("rst_empty",      64'(empty), 1);
    check("rst_consumed",   64'(consumed_cnt), 0);
    check("rst_overflow",   64'(overflow_err), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single push, visible next cycle, then popped.
    cyc(1, mk(5, 16'h0ABC), 0, 0);
    set_in(0, '0, 1, 0);
    #1;
    check("t1_head_valid", 64'(head_valid), 1);
    check("t1_head_idx",   64'(head_idx), 5);
    check("t1_head_data",  64'(head_data), 16'h0ABC);
    check("t1_count",      64'(count), 1);
    check("t1_pop_act",    64'(pop_act), 1);
    @(posedge clk); #1;
    set_in(0, '0, 0, 0);
    check("t1_empty",    64'(empty), 1);
    check("t1_consumed", 64'(consumed_cnt), 1);

    // Fill to full, then an overflowing push.
    for (int i = 0; i < DEPTH; i++) cyc(1, mk(10 + i, $urandom), 0, 0);
    set_in(0, '0, 0, 0);
    #1;
    check("t2_full",  64'(full), 1);
    check("t2_count", 64'(count), 8);
    cyc(1, mk(999, 16'h1234), 0, 0);
    set_in(0, '0, 0, 0);
    #1;
    check("t2_overflow", 64'(overflow_err), 1);
    check("t2_count_kept", 64'(count), 8);
    check("t2_head_first", 64'(head_idx), 10);

    // Push at full with a simultaneous pop.
    set_in(1, mk(9, 16'h0099), 1, 0);
    #1;
    check("t3_pop_at_full", 64'(pop_act), 1);
    @(posedge clk); #1;
    set_in(0, '0, 1, 0);
    check("t3_count", 64'(count), 8);
    for (int k = 1; k <= DEPTH; k++) begin
      #1;
      if (k == DEPTH) check("t3_eighth_head", 64'(head_idx), 9);
      @(posedge clk); #1;
    end
    check("t3_drained", 64'(empty), 1);

    // Streaming push+pop across pointer wrap.
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      set_in(1, mk(i, $urandom), 1, 0);
      #1;
      if (i > 0) begin
        check("t4_head_order", 64'(head_idx), 64'(i - 1));
        check("t4_count_one",  64'(count), 1);
      end
      @(posedge clk); #1;
    end
    set_in(0, '0, 1, 0);
    #1;
    check("t4_last_head", 64'(head_idx), 19);
    @(posedge clk); #1;
    set_in(0, '0, 0, 0);
    check("t4_consumed", 64'(consumed_cnt), 20);
    check("t4_empty",    64'(empty), 1);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 60), mk($urandom, $urandom),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
    end

    // Flush with three entries while push and pop are requested.
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, mk(100 + i, $urandom), 0, 0);
    set_in(1, mk(200, 16'h00AA), 1, 1);
    #1;
    check("t5_count_before", 64'(count), 3);
    check("t5_pop_blocked",  64'(pop_act), 0);
    @(posedge clk); #1;
    set_in(0, '0, 0, 0);
    check("t5_count",    64'(count), 0);
    check("t5_empty",    64'(empty), 1);
    check("t5_consumed", 64'(consumed_cnt), 0);
    check("t5_overflow", 64'(overflow_err), 1);

    // Asynchronous reset between edges with four entries queued.
    for (int i = 0; i < 4; i++) cyc(1, mk(40 + i, $urandom), 0, 0);
    set_in(0, '0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_count",      64'(count), 0);
    check("t6_head_valid", 64'(head_valid), 0);
    check("t6_empty",      64'(empty), 1);
    check("t6_overflow",   64'(overflow_err), 0);
    #3;
    rst = 1'b1;
    cyc(1, mk(77, 16'h7777), 0, 0);
    set_in(0, '0, 0, 0);
    #1;
    check("t6_head_idx",   64'(head_idx), 77);
    check("t6_head_data",  64'(head_data), 16'h7777);
    check("t6_count_one",  64'(count), 1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pe_act_queue

// File: doc/pe_act_queue.md
Name: pe_act_queue

Overview:
- Activation queue inside the processing element, directly downstream of the network interface's activation push path.
- Buffers activation entries pushed by the network interface (push_act/act) and presents them first-word-fall-through to the PE MAC datapath.
- Returns pop_act to the network interface, which uses it to release its credit for that queue slot.
- Also counts consumed entries per layer, provides occupancy/status, and supports a layer flush.

Parameters:
- DEPTH, 8, number of queue entries; power of two, ≥2.
- DATA_WIDTH, 16, activation value width (PE data bus).
- IDX_WIDTH, 10, activation index width (PE activation-number bus).
- CNT_WIDTH, 16, per-layer consumed-entry counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- push_act  in  1  push strobe from network interface.
- act  in  IDX_WIDTH+DATA_WIDTH  pushed entry {idx, data}; idx in upper bits.
- pop_act  out  1  entry consumed this cycle (to network interface credit).
- head_valid  out  1  head entry valid.
- head_idx  out  IDX_WIDTH  head activation index.
- head_data  out  DATA_WIDTH  head activation value.
- mac_ready  in  1  MAC datapath accepts head this cycle.
- flush  in  1  synchronous clear of queue contents and counter (layer boundary).
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- consumed_cnt  out  CNT_WIDTH  entries popped since reset/flush.
- overflow_err  out  1  sticky: push dropped because queue full.

Behaviour:
- Reset (rst=0, async): rd/wr pointers=0, count=0, head_valid=0, head_idx=0, head_data=0, consumed_cnt=0, overflow_err=0; pop_act=0, full=0, empty=1.
- Storage: DEPTH-entry register array plus wr_ptr/rd_ptr of $clog2(DEPTH) bits; both wrap naturally from DEPTH-1 to 0.
- Head output: combinational read of mem[rd_ptr]; head_valid = (count != 0).
- Push latency: entry pushed at cycle N is visible at head at N+1 when queue was empty. There is no same-cycle bypass.
- pop_act = head_valid & mac_ready & ~flush (combinational). When pop_act=1, rd_ptr increments, count decrements, and consumed_cnt increments.
- Push accepted when push_act & (~full | pop_act) & ~flush. On accept: mem[wr_ptr] <= act, wr_ptr increments, count increments.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - At full with a simultaneous pop: push accepted.
  - At empty: a pop is impossible (head_valid=0), so the push alone takes effect.
- Push while full with no pop: entry dropped, state unchanged, overflow_err <= 1 (sticky until reset only; flush does not clear it). The network interface's credit flow control guarantees this never happens; it is an assertion target.
- consumed_cnt saturates at all-ones.
- mac_ready while empty: no effect, pop_act=0.
- flush=1 has priority over push and pop. Next cycle: pointers=0, count=0, head_valid=0, consumed_cnt=0; push/pop in the flush cycle are ignored, with pop_act forced 0.
- Reset asserted mid-operation: immediate clear to reset values regardless of clk; contents discarded.
- No X propagation: head_idx/head_data are driven from the array (array need not be reset); checkers sample head fields only when head_valid=1.

Decomposition:
- Shared pe package (pe.vh): queue entry width macro (PEQueueBus = IDX_WIDTH+DATA_WIDTH), field select macros for idx/data, default DEPTH.
- One sub-module is natural: sync_fifo_ptr (pointer/count bookkeeping with full/empty and simultaneous push/pop rules), reusable elsewhere in the PE.
- The array, flush, counters and error flag stay in pe_act_queue.

Test Plan:
- Reset then single push act={idx=5,data=0x0ABC} at cycle 1 -> cycle 2: head_valid=1, head_idx=5, head_data=0x0ABC, count=1; mac_ready at cycle 2 -> pop_act=1, cycle 3 empty=1, consumed_cnt=1.
- 8 pushes with mac_ready=0 -> full=1, count=8; 9th push -> dropped, overflow_err=1, count stays 8, head still first entry.
- Full queue, push idx=9 with mac_ready=1 same cycle -> pop_act=1, count stays 8, idx=9 emerges as 8th subsequent head.
- Continuous push+pop for 20 cycles of incrementing idx 0..19 -> heads appear in order 0..19 across pointer wrap, consumed_cnt=20, count constant at 1.
- Queue holding 3 entries, flush=1 with push_act=1 and mac_ready=1 -> pop_act=0; next cycle count=0, empty=1, consumed_cnt=0, overflow_err unchanged.
- Assert rst=0 asynchronously between clock edges with count=4 -> outputs immediately reach reset values; after release, first push appears at head one cycle later.
